wb_sram_bist_master: RTL

- Wishbone master that drives the interconnect's master port and exercises the SRAM slave.
- Two passes: a write pass fills words ADDR_START..ADDR_END with a generated pattern, then a read pass regenerates the pattern and compares each returned word.
- Reports pass/fail, error count, first failing address/data and bus timeout; used for post-silicon SRAM bring-up from LA/management control bits.

---
 rtl/wb_sram_bist_master_if.sv | 25 ++
 rtl/wb_sram_bist_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_bist_master_if.sv
// Wishbone classic bus between the BIST master and the SRAM slave port.
// Signal suffixes are from the master's point of view.
interface wb_sram_bist_master_if #(
   parameter int unsigned ADDR_WD = 9,
   parameter int unsigned DATA_WD = 32
);
   logic               cyc_o;
   logic               stb_o;
   logic               we_o;
   logic [ADDR_WD-1:0] adr_o;
   logic [3:0]         sel_o;
   logic [DATA_WD-1:0] dat_o;
   logic [DATA_WD-1:0] dat_i;
   logic               ack_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
      output dat_i, ack_i
   );
endinterface

// File: rtl/wb_sram_bist_master.sv
// SRAM bring-up BIST: write pass fills ADDR_START..ADDR_END with a pattern,
// read pass regenerates it and compares, reporting errors and bus timeouts.
module wb_sram_bist_master #(
   parameter int unsigned        ADDR_WD     = 9,
   parameter int unsigned        DATA_WD     = 32,
   parameter logic [ADDR_WD-1:0] ADDR_START  = 9'h000,
   parameter logic [ADDR_WD-1:0] ADDR_END    = 9'h1F8,
   parameter int unsigned        TIMEOUT_CYC = 255
) (
   input  logic                      wb_clk_i,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [1:0]                pat_sel_i,
   input  logic [DATA_WD-1:0]        seed_i,
   wb_sram_bist_master_if.master     m_wb,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      pass_o,
   output logic                      timeout_o,
   output logic [15:0]               err_cnt_o,
   output logic [ADDR_WD-1:0]        first_err_adr_o,
   output logic [DATA_WD-1:0]        first_err_dat_o
);

   localparam logic [DATA_WD-1:0] LFSR_TAPS = 32'h80200003;
   localparam logic [7:0]         TMO_LAST  = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_GAP,
      ST_RD_REQ,
      ST_RD_GAP,
      ST_DONE
   } state_t;

   state_t             state_q,    state_d;
   logic [1:0]         pat_sel_q,  pat_sel_d;
   logic [DATA_WD-1:0] seed_q,     seed_d;
   logic [ADDR_WD-1:0] adr_q,      adr_d;
   logic [DATA_WD-1:0] lfsr_q,     lfsr_d;
   logic               last_q,     last_d;
   logic [7:0]         tmo_q,      tmo_d;
   logic               done_q,     done_d;
   logic               pass_q,     pass_d;
   logic               timeout_q,  timeout_d;
   logic [15:0]        err_cnt_q,  err_cnt_d;
   logic [ADDR_WD-1:0] ferr_adr_q, ferr_adr_d;
   logic [DATA_WD-1:0] ferr_dat_q, ferr_dat_d;

   logic [DATA_WD-1:0] adr_ext;
   logic [DATA_WD-1:0] pat;
   logic               in_req;

   // Right-shifting Galois LFSR, one step per completed transfer.
   function automatic logic [DATA_WD-1:0] lfsr_step(input logic [DATA_WD-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

   // An all-zero LFSR would lock up, so a zero seed starts from 1.
   function automatic logic [DATA_WD-1:0] lfsr_init(input logic [DATA_WD-1:0] s);
      return (s == '0) ? {{(DATA_WD-1){1'b0}}, 1'b1} : s;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_comb begin
      adr_ext = {{(DATA_WD-ADDR_WD){1'b0}}, adr_q};
      unique case (pat_sel_q)
         2'd0:    pat = adr_ext;
         2'd1:    pat = ~adr_ext;
         2'd2:    pat = seed_q;
         default: pat = lfsr_q;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pat_sel_q  <= '0;
         seed_q     <= '0;
         adr_q      <= '0;
         lfsr_q     <= '0;
         last_q     <= 1'b0;
         tmo_q      <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         err_cnt_q  <= '0;
         ferr_adr_q <= '0;
         ferr_dat_q <= '0;
      end else begin
         state_q    <= state_d;
         pat_sel_q  <= pat_sel_d;
         seed_q     <= seed_d;
         adr_q      <= adr_d;
         lfsr_q     <= lfsr_d;
         last_q     <= last_d;
         tmo_q      <= tmo_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         err_cnt_q  <= err_cnt_d;
         ferr_adr_q <= ferr_adr_d;
         ferr_dat_q <= ferr_dat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pat_sel_d  = pat_sel_q;
      seed_d     = seed_q;
      adr_d      = adr_q;
      lfsr_d     = lfsr_q;
      last_d     = last_q;
      tmo_d      = '0;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      err_cnt_d  = err_cnt_q;
      ferr_adr_d = ferr_adr_q;
      ferr_dat_d = ferr_dat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               pat_sel_d  = pat_sel_i;
               seed_d     = seed_i;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               err_cnt_d  = '0;
               ferr_adr_d = '0;
               ferr_dat_d = '0;
               adr_d      = ADDR_START;
               lfsr_d     = lfsr_init(seed_i);
               last_d     = 1'b0;
               state_d    = ST_WR_REQ;
            end
         end

         ST_WR_REQ, ST_RD_REQ: begin
            if (m_wb.ack_i) begin
               state_d = (state_q == ST_RD_REQ) ? ST_RD_GAP : ST_WR_GAP;
               last_d  = (adr_q == ADDR_END);
               adr_d   = adr_q + 1'b1;
               lfsr_d  = lfsr_step(lfsr_q);
               if (state_q == ST_RD_REQ && m_wb.dat_i != pat) begin
                  err_cnt_d = sat_inc(err_cnt_q);
                  if (err_cnt_q == '0) begin
                     ferr_adr_d = adr_q;
                     ferr_dat_d = m_wb.dat_i;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               // Slave is stuck: abandon the test rather than hang the bus.
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         ST_WR_GAP: begin
            if (last_q) begin
               adr_d   = ADDR_START;
               lfsr_d  = lfsr_init(seed_q);
               last_d  = 1'b0;
               state_d = ST_RD_REQ;
            end else begin
               state_d = ST_WR_REQ;
            end
         end

         ST_RD_GAP: begin
            if (last_q) begin
               done_d  = 1'b1;
               pass_d  = (err_cnt_q == '0) && !timeout_q;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RD_REQ;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs decode straight from the state register so reset drops them at once.
   assign in_req      = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
   assign m_wb.cyc_o  = in_req;
   assign m_wb.stb_o  = in_req;
   assign m_wb.we_o   = (state_q == ST_WR_REQ);
   assign m_wb.adr_o  = in_req ? adr_q : '0;
   assign m_wb.sel_o  = in_req ? 4'hF : 4'h0;
   assign m_wb.dat_o  = (state_q == ST_WR_REQ) ? pat : '0;

   assign busy_o          = in_req || (state_q == ST_WR_GAP) || (state_q == ST_RD_GAP);
   assign done_o          = done_q;
   assign pass_o          = pass_q;
   assign timeout_o       = timeout_q;
   assign err_cnt_o       = err_cnt_q;
   assign first_err_adr_o = ferr_adr_q;
   assign first_err_dat_o = ferr_dat_q;

endmodule
